// File: rtl/seguranca_pkg.sv
// Shared definitions for the home-security access controller.
// Holds the FSM state encoding and the default timing constants used as
// parameter defaults by controle_acesso.
package seguranca_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    LIBERADO  = 2'd1,
    BLOQUEADO = 2'd2,
    ALARME    = 2'd3
  } estado_t;

  localparam int MAX_TENTATIVAS_PADRAO = 3;
  localparam int T_ABERTO_PADRAO       = 10;
  localparam int T_BLOQUEIO_PADRAO     = 20;
  localparam int TW_PADRAO             = 8;

endpackage

// File: rtl/temporizador.sv
// Loadable saturating down-counter shared by the unlock and lockout timeouts.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset (counter cleared to 0)
//   carregar - load strobe; carga is captured on the next rising edge
//   carga    - value to load
//   valor    - current count
//   zero     - high while the count is 0
// The count decrements once per cycle and stops at 0 (never wraps).
module temporizador #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carregar,
  input  logic [TW-1:0] carga,
  output logic [TW-1:0] valor,
  output logic          zero
);

  logic [TW-1:0] valor_d, valor_q;

  // NOTE: combinational blocks use blocking '=' and assign a default first so
  // every path drives valor_d and no latch is inferred.
  always_comb begin
    valor_d = valor_q;
    if (carregar) begin
      valor_d = carga;
    end else if (valor_q != '0) begin
      valor_d = valor_q - TW'(1);
    end
  end

  // NOTE: state flops use non-blocking '<=' so all registers update together
  // from values sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valor_q <= '0;
    else       valor_q <= valor_d;
  end

  assign valor = valor_q;
  assign zero  = (valor_q == '0);

endmodule

// File: rtl/controle_acesso.sv
// Access-control FSM downstream of the 4-bit code comparator.
// Samples the comparator's equality flag on each confirm strobe, drives the
// door lock, counts failed attempts, enforces a timed lockout and latches an
// alarm on forced entry.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   confirma     - single-cycle strobe: user submitted a code
//   igual        - comparator equality flag, valid while confirma=1
//   sensor_porta - door sensor (1 = open)
//   trava        - lock drive (1 = locked), registered
//   alarme       - siren drive, registered
//   bloqueado    - high during lockout, registered
//   tentativas   - failed-attempt count, registered
module controle_acesso
  import seguranca_pkg::*;
#(
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO,
  parameter int T_ABERTO       = T_ABERTO_PADRAO,
  parameter int T_BLOQUEIO     = T_BLOQUEIO_PADRAO,
  parameter int TW             = TW_PADRAO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       confirma,
  input  logic       igual,
  input  logic       sensor_porta,
  output logic       trava,
  output logic       alarme,
  output logic       bloqueado,
  output logic [1:0] tentativas
);

  localparam logic [2:0]    MAX_T          = 3'(MAX_TENTATIVAS);
  localparam logic [TW-1:0] CARGA_ABERTO   = TW'(T_ABERTO - 1);
  localparam logic [TW-1:0] CARGA_BLOQUEIO = TW'(T_BLOQUEIO - 1);

  estado_t       estado_d, estado_q;
  logic [1:0]    tentativas_d, tentativas_q;
  logic          trava_d, trava_q;
  logic          alarme_d, alarme_q;
  logic          bloqueado_d, bloqueado_q;
  logic          timer_carregar;
  logic [TW-1:0] timer_carga;
  logic [TW-1:0] timer_valor;
  logic          timer_zero;
  logic [2:0]    prox_falhas;

  temporizador #(.TW(TW)) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .carregar (timer_carregar),
    .carga    (timer_carga),
    .valor    (timer_valor),
    .zero     (timer_zero)
  );

  // Widened so the +1 cannot overflow before the comparison with the limit.
  assign prox_falhas = {1'b0, tentativas_q} + 3'd1;

  always_comb begin
    estado_d       = estado_q;
    tentativas_d   = tentativas_q;
    timer_carregar = 1'b0;
    timer_carga    = '0;
    unique case (estado_q)
      OCIOSO: begin
        // Forced entry wins over any code submitted in the same cycle.
        if (sensor_porta) begin
          estado_d = ALARME;
        end else if (confirma && igual) begin
          estado_d       = LIBERADO;
          tentativas_d   = '0;
          timer_carregar = 1'b1;
          timer_carga    = CARGA_ABERTO;
        end else if (confirma) begin
          if (prox_falhas < MAX_T) begin
            tentativas_d = prox_falhas[1:0];
          end else begin
            estado_d       = BLOQUEADO;
            tentativas_d   = MAX_T[1:0];
            timer_carregar = 1'b1;
            timer_carga    = CARGA_BLOQUEIO;
          end
        end
      end
      LIBERADO: begin
        // Door sensor only matters once the unlock window has elapsed; an
        // open door keeps us here with the timer parked at 0.
        if (timer_zero && !sensor_porta) estado_d = OCIOSO;
      end
      BLOQUEADO: begin
        if (sensor_porta) begin
          estado_d = ALARME;
        end else if (timer_zero) begin
          estado_d     = OCIOSO;
          tentativas_d = '0;
        end
      end
      ALARME: begin
        if (confirma && igual) begin
          estado_d     = OCIOSO;
          tentativas_d = '0;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Outputs decoded from the next state so they are registered yet still
    // change on the same edge as the state.
    trava_d     = (estado_d != LIBERADO);
    alarme_d    = (estado_d == ALARME);
    bloqueado_d = (estado_d == BLOQUEADO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      tentativas_q <= '0;
      trava_q      <= 1'b1;
      alarme_q     <= 1'b0;
      bloqueado_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      tentativas_q <= tentativas_d;
      trava_q      <= trava_d;
      alarme_q     <= alarme_d;
      bloqueado_q  <= bloqueado_d;
    end
  end

  // The counter's zero flag and its count must always agree.
  assert property (@(posedge clk) disable iff (reset)
                   timer_zero == (timer_valor == '0));

  assign trava      = trava_q;
  assign alarme     = alarme_q;
  assign bloqueado  = bloqueado_q;
  assign tentativas = tentativas_q;

endmodule
